// File: rtl/pulse_meter_pkg.sv
// rtl/pulse_meter_pkg.sv - shared types and helpers for the pulse measurement stage
//
// Purpose:
//   Common definitions for chan_pulse_meter and related blocks:
//   - the measurement FSM state enum
//   - the default counter/result width
//   - a saturating increment helper
// Ports: none (package).
package pulse_meter_pkg;

  localparam int unsigned W_DEFAULT = 16;

  typedef enum logic [1:0] {
    ARM    = 2'd0,
    MEAS_H = 2'd1,
    MEAS_L = 2'd2
  } meas_state_e;

  // Operates on a 32-bit container so one function serves every width up to 32.
  // Callers zero-extend the operand and the ceiling, then truncate the result.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] vmax);
    return (v >= vmax) ? vmax : v + 32'd1;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - multi-flop synchroniser with registered-previous edge detect
//
// Purpose:
//   Brings an asynchronous level into the i_clk domain and flags its edges.
//   The same block is reused by other trigger-path blocks.
// Ports:
//   i_clk    in   sampling clock, rising edge
//   i_rst_n  in   synchronous active-low reset; clears the sync chain and the previous-level flop
//   i_d      in   asynchronous input level
//   o_s      out  synchronised level
//   o_rise   out  s high while the previous s was low
//   o_fall   out  s low while the previous s was high
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_s,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_p;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync <= '0;
      r_p    <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      r_p    <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_s    = r_sync[SYNC_STAGES-1];
  assign o_rise = o_s & ~r_p;
  assign o_fall = ~o_s & r_p;

endmodule

// File: rtl/chan_pulse_meter.sv
// rtl/chan_pulse_meter.sv - per-channel rising-edge counter and low/high pulse-width meter
//
// Purpose:
//   Synchronises Din, counts rising edges per Gate window and measures the most
//   recent complete low and high pulse widths in Clk cycles. All outputs are
//   registered so an asynchronous reader sees coherent words.
// Ports:
//   Clk   in   sampling clock, rising edge
//   nRst  in   synchronous active-low reset
//   Din   in   raw channel input, asynchronous to Clk
//   En    in   measurement enable
//   Gate  in   one-cycle strobe closing the edge-count window
//   Edge  out  rising edges counted in the last closed window
//   TL    out  last complete low-pulse width, cycles
//   TH    out  last complete high-pulse width, cycles
//   New   out  one-cycle strobe, Edge updated
module chan_pulse_meter
  import pulse_meter_pkg::*;
#(
  parameter int W           = W_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic         Clk,
  input  logic         nRst,
  input  logic         Din,
  input  logic         En,
  input  logic         Gate,
  output logic [W-1:0] Edge,
  output logic [W-1:0] TL,
  output logic [W-1:0] TH,
  output logic         New
);

  localparam logic [W-1:0] MAX = '1;
  // The sync chain and p are cleared by reset, so a Din that is already high
  // at release looks like a rise. Edges are ignored until every flop in the
  // chain plus p holds a genuinely sampled value.
  localparam int WARM = SYNC_STAGES + 1;
  localparam int WW   = $clog2(WARM + 1);

  logic              w_s;
  logic              w_rise;
  logic              w_fall;
  logic              w_rise_q;
  logic              w_fall_q;
  logic              w_warm_done;
  logic              w_wc_max;
  logic [W-1:0]      w_wc_inc;
  logic [W-1:0]      w_ec_inc;
  logic [W-1:0]      w_ec_rise;
  logic              w_lat_th;
  logic              w_lat_tl;
  meas_state_e       w_state_nxt;

  meas_state_e       r_state;
  logic [W-1:0]      r_wc;
  logic [W-1:0]      r_ec;
  logic [W-1:0]      r_edge;
  logic [W-1:0]      r_tl;
  logic [W-1:0]      r_th;
  logic              r_new;
  logic [WW-1:0]     r_warm;

  sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk   (Clk),
    .i_rst_n (nRst),
    .i_d     (Din),
    .o_s     (w_s),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  assign w_warm_done = (r_warm == WW'(WARM));
  assign w_rise_q    = w_rise & w_warm_done;
  assign w_fall_q    = w_fall & w_warm_done;

  assign w_wc_max  = (r_wc == MAX);
  assign w_wc_inc  = W'(sat_inc(32'(r_wc), 32'(MAX)));
  assign w_ec_inc  = W'(sat_inc(32'(r_ec), 32'(MAX)));
  // Edge count including a rise detected in this very cycle.
  assign w_ec_rise = w_rise_q ? w_ec_inc : r_ec;

  // FSM: state register
  always_ff @(posedge Clk) begin
    if (!nRst) begin
      r_state <= ARM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM: next state. The first edge seen from ARM only selects the phase;
  // the pulse that was already in progress is never measured.
  always_comb begin
    w_state_nxt = r_state;
    if (!En) begin
      w_state_nxt = ARM;
    end else begin
      case (r_state)
        ARM: begin
          if (w_rise_q)      w_state_nxt = MEAS_H;
          else if (w_fall_q) w_state_nxt = MEAS_L;
        end
        MEAS_H:  if (w_fall_q) w_state_nxt = MEAS_L;
        MEAS_L:  if (w_rise_q) w_state_nxt = MEAS_H;
        default: w_state_nxt = ARM;
      endcase
    end
  end

  // FSM: outputs. A width counter stuck at its ceiling publishes the ceiling
  // straight away so a dead input is visible without waiting for an edge.
  always_comb begin
    w_lat_th = 1'b0;
    w_lat_tl = 1'b0;
    if (En) begin
      w_lat_th = (r_state == MEAS_H) && (w_fall_q || (w_wc_max && w_s));
      w_lat_tl = (r_state == MEAS_L) && (w_rise_q || (w_wc_max && !w_s));
    end
  end

  // Datapath: width counter, edge counter, result registers
  always_ff @(posedge Clk) begin
    if (!nRst) begin
      r_wc   <= '0;
      r_ec   <= '0;
      r_edge <= '0;
      r_tl   <= '0;
      r_th   <= '0;
      r_new  <= 1'b0;
      r_warm <= '0;
    end else begin
      if (!w_warm_done) begin
        r_warm <= r_warm + WW'(1);
      end
      r_new <= En & Gate;
      if (!En) begin
        r_wc <= '0;
        r_ec <= '0;
      end else begin
        // Loading 1 on the edge makes the latched value equal the distance
        // between the two edge-detect cycles.
        r_wc <= (w_rise_q | w_fall_q) ? W'(1) : w_wc_inc;
        if (Gate) begin
          r_edge <= w_ec_rise;
          r_ec   <= '0;
        end else begin
          r_ec   <= w_ec_rise;
        end
      end
      if (w_lat_th) r_th <= r_wc;
      if (w_lat_tl) r_tl <= r_wc;
    end
  end

  assign Edge = r_edge;
  assign TL   = r_tl;
  assign TH   = r_th;
  assign New  = r_new;

endmodule
